// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two masters with a starvation cap and lock bursts.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 0 wins ties.
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);
  localparam int TW = 2 * RD_LAT;
  localparam logic [3:0] HMAX = 4'(MAX_HOLD);
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;
  owner_t owner_q, owner_d;
  logic lock_q, lock_d, rr_last_q, rr_last_d;
  logic [3:0] hold_q, hold_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic act, sel, sel_we, tie_sel, owner_m1, owner_valid, owner_req, other_req, cap;
  logic [1:0] tag_out;
  always_comb begin
    act         = rst_n & (m0_req | m1_req);
    owner_m1    = owner_q == OWN_M1;
    owner_valid = owner_q != OWN_NONE;
    owner_req   = owner_m1 ? m1_req : m0_req;
    other_req   = owner_m1 ? m0_req : m1_req;
    cap         = owner_valid && hold_q == HMAX && other_req;
`ifdef ARB_ROUND_ROBIN_EN
    tie_sel     = ~rr_last_q;
`else
    tie_sel     = 1'b0;
`endif
    sel = cap ? ~owner_m1 :
          (lock_q && owner_valid && owner_req) ? owner_m1 :
          (m0_req ^ m1_req) ? m1_req : tie_sel;
    m0_gnt     = act & ~sel;
    m1_gnt     = act & sel;
    sel_we     = sel ? m1_we : m0_we;
    ram_w_en   = act & sel_we;
    ram_addr   = act ? (sel ? m1_addr : m0_addr) : '0;
    ram_w_data = act ? (sel ? m1_wdata : m0_wdata) : '0;
    owner_d    = !act ? OWN_NONE : sel ? OWN_M1 : OWN_M0;
    lock_d     = act & (sel ? m1_lock : m0_lock);
    // Count only while the same master keeps winning against a waiting rival.
    hold_d = !act ? 4'd0 :
             (owner_valid && sel == owner_m1 && (sel ? m0_req : m1_req)) ?
             ((hold_q == HMAX) ? hold_q : hold_q + 4'd1) : 4'd1;
    rr_last_d  = act ? sel : rr_last_q;
    tag_d      = TW'({tag_q, act & ~sel_we, sel});
    tag_out    = tag_q[TW-1 -: 2];
    m0_rvalid  = tag_out[1] & ~tag_out[0];
    m1_rvalid  = tag_out[1] & tag_out[0];
    m0_rdata   = m0_rvalid ? ram_r_data : m0_rdata_q;
    m1_rdata   = m1_rvalid ? ram_r_data : m1_rdata_q;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      lock_q     <= 1'b0;
      hold_q     <= 4'd0;
      rr_last_q  <= 1'b1;
      tag_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      hold_q     <= hold_d;
      rr_last_q  <= rr_last_d;
      tag_q      <= tag_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a write-first RAM model.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [7:0] m0_addr, m1_addr, ram_addr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_w_data, ram_r_data;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_w_en;
  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  logic prev_m1;
  logic exp_m1;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_w_data;
    ram_r_data <= ram_w_en ? ram_w_data : mem[ram_addr];
  end

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    m0_addr = 8'h00; m1_addr = 8'h00; m0_wdata = 16'h0; m1_wdata = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    rst_n = 1'b1;
    next_cycle();
    chk("idle_w_en", ram_w_en, 0);
    chk("idle_addr", ram_addr, 0);
    chk("idle_wdata", ram_w_data, 0);
    chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
    chk("idle_rvalid", {m0_rvalid, m1_rvalid}, 0);
    m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 16'hBEEF;
    #1;
    chk("m0_wr_gnt", m0_gnt, 1);
    chk("m0_wr_w_en", ram_w_en, 1);
    chk("m0_wr_addr", ram_addr, 8'h10);
    chk("m0_wr_data", ram_w_data, 16'hBEEF);
    next_cycle();
    m0_we = 0;
    #1;
    chk("m0_rd_gnt", m0_gnt, 1);
    chk("m0_rd_w_en", ram_w_en, 0);
    chk("m0_rd_no_rvalid_for_write", m0_rvalid, 0);
    next_cycle();
    m0_req = 0;
    #1;
    chk("m0_rvalid", m0_rvalid, 1);
    chk("m0_rdata", m0_rdata, 16'hBEEF);
    chk("m1_rvalid_quiet", m1_rvalid, 0);
    next_cycle();
    m1_req = 1; m1_we = 1; m1_addr = 8'h20; m1_wdata = 16'h1234;
    #1;
    chk("m1_wr_gnt", m1_gnt, 1);
    chk("m1_wr_w_en", ram_w_en, 1);
    chk("m1_wr_addr", ram_addr, 8'h20);
    chk("m0_rdata_hold", m0_rdata, 16'hBEEF);
    chk("m0_rvalid_low", m0_rvalid, 0);
    next_cycle();
    m1_we = 0;
    #1;
    chk("m1_rd_gnt", m1_gnt, 1);
    chk("m1_rd_w_en", ram_w_en, 0);
    next_cycle();
    m1_req = 0;
    #1;
    chk("m1_rvalid", m1_rvalid, 1);
    chk("m1_rdata", m1_rdata, 16'h1234);
    chk("m0_rvalid_low2", m0_rvalid, 0);
    next_cycle();
    m0_req = 1; m1_req = 1;
    prev_m1 = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_m1 = (i % 2) == 1;
`else
      exp_m1 = (i % 5) == 4;
`endif
      chk($sformatf("tie_m1_gnt_%0d", i), m1_gnt, exp_m1);
      chk($sformatf("tie_m0_gnt_%0d", i), m0_gnt, !exp_m1);
      if (i > 0) begin
        chk($sformatf("tie_m1_rvalid_%0d", i), m1_rvalid, prev_m1);
        chk($sformatf("tie_m0_rvalid_%0d", i), m0_rvalid, !prev_m1);
      end
      prev_m1 = exp_m1;
      next_cycle();
    end
    m0_req = 0; m1_req = 0;
    #1;
    chk("tie_tail_m1_rvalid", m1_rvalid, 1);
    chk("tie_tail_m1_rdata", m1_rdata, 16'h1234);
    chk("tie_tail_gnt", {m0_gnt, m1_gnt}, 0);
    next_cycle();
    m1_req = 1; m1_lock = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) m0_req = 1;
      if (i == 5) m0_req = 0;
      #1;
      chk($sformatf("lock_m1_gnt_%0d", i), m1_gnt, i != 4);
      if (i == 4) chk("lock_cap_m0_gnt", m0_gnt, 1);
      next_cycle();
    end
    m1_req = 0; m1_lock = 0;
    next_cycle();
    m0_req = 1; m0_addr = 8'h10;
    #1;
    chk("rstmid_m0_gnt", m0_gnt, 1);
    rst_n = 0;
    next_cycle();
    rst_n = 1; m0_req = 0;
    #1;
    chk("rstmid_no_rvalid0", m0_rvalid, 0);
    next_cycle();
    chk("rstmid_no_rvalid1", m0_rvalid, 0);
    m0_req = 1; m1_req = 1;
    #1;
    chk("rstmid_tie_m0_first", m0_gnt, 1);
    next_cycle();
`ifdef ARB_ROUND_ROBIN_EN
    chk("rstmid_tie_second", m1_gnt, 1);
`else
    chk("rstmid_tie_second", m0_gnt, 1);
`endif
    m0_req = 0; m1_req = 0;
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
